// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between the protocol initiator and the memory-backed slave.
// IDs, lock, cache and QoS are not carried.
interface axi_slave_mem_if #(
  parameter int AW = 32,
  parameter int DW = 64
) ();
  localparam int NB = DW / 8;

  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;

  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;

  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;

  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by a word memory; independent single write and read bursts.
// Define AXI_SLV_WRAP_EN to support WRAP bursts (otherwise WRAP answers SLVERR).
module axi_slave_mem #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 256
) (
  input logic             axi_aclk,
  input logic             rst,
  axi_slave_mem_if.slave  s
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int LD = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DW-1:0] mem [DEPTH];

  function automatic logic [LD-1:0] idx(input logic [AW-1:0] a);
    return a[LB +: LD];
  endfunction

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] a,
    input logic [2:0]    sz,
    input logic [1:0]    bu,
    input logic [7:0]    ln
  );
    logic [AW-1:0] inc;
    logic [AW-1:0] span;
    logic [AW-1:0] n;
    inc  = AW'(1) << sz;
    span = AW'({1'b0, ln} + 9'd1) << sz;
    unique case (1'b1)
      bu == 2'b00: n = a;
      bu == 2'b10: n = (a & ~(span - AW'(1)))
                     | ((a + inc) & (span - AW'(1)));
      default:     n = (a & ~(inc - AW'(1))) + inc;
    endcase
    return n;
  endfunction

`ifdef AXI_SLV_WRAP_EN
  function automatic logic wrap_bad(input logic [7:0] ln);
    return !(ln == 8'd1 || ln == 8'd3 || ln == 8'd7 || ln == 8'd15);
  endfunction
`endif

  function automatic logic chk(
    input logic [2:0] sz,
    input logic [1:0] bu,
    input logic [7:0] ln
  );
    logic e;
    e = (sz > 3'(LB)) || (bu == 2'b11);
`ifdef AXI_SLV_WRAP_EN
    if (bu == 2'b10) e = e || wrap_bad(ln);
`else
    if (bu == 2'b10 && ln == ln) e = 1'b1;
`endif
    return e;
  endfunction

  // ---------------- write channel
  w_state_e      w_state_q, w_state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wlen_q, wlen_d;
  logic [2:0]    wsize_q, wsize_d;
  logic [1:0]    wburst_q, wburst_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic          werr_q, werr_d;
  logic          mem_we;

  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: if (s.awvalid) begin
        waddr_d   = s.awaddr;
        wlen_d    = s.awlen;
        wsize_d   = s.awsize;
        wburst_d  = s.awburst;
        wcnt_d    = s.awlen;
        werr_d    = chk(s.awsize, s.awburst, s.awlen);
        w_state_d = W_DATA;
      end
      W_DATA: if (s.wvalid) begin
        mem_we  = !werr_q && !rst;
        werr_d  = werr_q | (s.wlast != (wcnt_q == 8'd0));
        waddr_d = nxt(waddr_q, wsize_q, wburst_q, wlen_q);
        wcnt_d  = wcnt_q - 8'd1;
        if (wcnt_q == 8'd0) w_state_d = W_RESP;
      end
      W_RESP: if (s.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (s.wstrb[b]) mem[idx(waddr_q)][b*8 +: 8] <= s.wdata[b*8 +: 8];
      end
    end
  end

  assign s.awready = (w_state_q == W_IDLE);
  assign s.wready  = (w_state_q == W_DATA);
  assign s.bvalid  = (w_state_q == W_RESP);
  assign s.bresp   = (s.bvalid && werr_q) ? 2'b10 : 2'b00;

  // ---------------- read channel
  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    rlen_q, rlen_d;
  logic [2:0]    rsize_q, rsize_d;
  logic [1:0]    rburst_q, rburst_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          rerr_q, rerr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          rlast_q, rlast_d;
  logic [AW-1:0] rnext;
  logic [DW-1:0] rword;
  logic          ar_err;

  // Read data is registered, so a same-edge write is seen only by later beats.
  assign rnext  = nxt(raddr_q, rsize_q, rburst_q, rlen_q);
  assign ar_err = chk(s.arsize, s.arburst, s.arlen);
  assign rword  = mem[idx(r_state_q == R_IDLE ? s.araddr : rnext)];

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      R_IDLE: if (s.arvalid) begin
        raddr_d   = s.araddr;
        rlen_d    = s.arlen;
        rsize_d   = s.arsize;
        rburst_d  = s.arburst;
        rcnt_d    = s.arlen;
        rerr_d    = ar_err;
        rdata_d   = ar_err ? '0 : rword;
        rresp_d   = ar_err ? 2'b10 : 2'b00;
        rlast_d   = (s.arlen == 8'd0);
        r_state_d = R_DATA;
      end
      R_DATA: if (s.rready) begin
        if (rcnt_q == 8'd0) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          raddr_d = rnext;
          rcnt_d  = rcnt_q - 8'd1;
          rdata_d = rerr_q ? '0 : rword;
          rlast_d = (rcnt_q == 8'd1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign s.arready = (r_state_q == R_IDLE);
  assign s.rvalid  = (r_state_q == R_DATA);
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;
  assign s.rlast   = rlast_q;
endmodule
